// File: rtl/protocol_in_pkg.sv
`default_nettype none
// ============================================================================
// Module   : protocol_in_pkg
// Brief    : Shared constants, state encoding and checksum helper for the
//            receive-side frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
package protocol_in_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

    typedef logic [1:0] state_t;
    localparam state_t ST_HUNT     = 2'd0;
    localparam state_t ST_GOT_HDR  = 2'd1;
    localparam state_t ST_GOT_CMD  = 2'd2;
    localparam state_t ST_GOT_DATA = 2'd3;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_CMD  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_CHAN = 2'd1;
    localparam logic [1:0] ADDR_GATE = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam logic [5:0] CMD_PREFIX = 6'b000001;

    // 8-bit wrapping sum that the transmitter places in the CHK byte
    function automatic logic [7:0] frame_sum(input logic [7:0] hdr,
                                             input logic [7:0] cmd,
                                             input logic [7:0] data);
        return hdr + cmd + data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/protocol_in_if.sv
`default_nettype none
// ============================================================================
// Module   : protocol_in_if
// Brief    : Byte-strobe input and configuration/status outputs of the
//            frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface protocol_in_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] sw_out;
    logic [7:0] chan_mask;
    logic [7:0] gate_div;
    logic       cmd_valid;
    logic [1:0] cmd_addr;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_data, rx_valid,
        input  sw_out, chan_mask, gate_div, cmd_valid, cmd_addr,
               frame_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output sw_out, chan_mask, gate_div, cmd_valid, cmd_addr,
               frame_err, err_code, busy
    );

endinterface
`default_nettype wire

// File: rtl/protocol_in_frame_timeout.sv
`default_nettype none
// ============================================================================
// Module   : protocol_in_frame_timeout
// Brief    : Saturating inter-byte counter; pulses o_expire on the cycle the
//            count sits at TIMEOUT_CYCLES-1 and nothing clears it.
// Revision : 1.0 - initial release
// ============================================================================
module protocol_in_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 2400
) (
    input  wire logic clk_in,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    localparam int                c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_at_last;

    assign w_at_last = (r_count == c_LAST);
    assign o_expire  = i_enable & ~i_clear & w_at_last;

    // Holds at the last value instead of wrapping
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/protocol_in.sv
`default_nettype none
// ============================================================================
// Module   : protocol_in
// Brief    : Hunts for HEADER, assembles HEADER/CMD/DATA/CHK frames, validates
//            them and writes a four-entry configuration register file.
// Revision : 1.0 - initial release
// ============================================================================
module protocol_in
    import protocol_in_pkg::*;
#(
    parameter logic [7:0] HEADER         = HEADER_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2400,
    parameter logic [7:0] SW_RESET_VAL   = 8'h00
) (
    input  wire logic    clk_in,
    input  wire logic    reset,
    protocol_in_if.slave bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cmd;
    logic [7:0] r_data;
    logic [7:0] r_regs [4];
    logic       r_cmd_valid;
    logic       r_frame_err;
    logic [1:0] r_cmd_addr;
    logic [1:0] r_err_code;

    logic       w_in_hunt;
    logic       w_tmo_clear;
    logic       w_expire;
    logic       w_chk_ok;
    logic       w_cmd_ok;
    logic       w_lat_cmd;
    logic       w_lat_data;
    logic       w_write;
    logic       w_err;
    logic [1:0] w_err_val;

    assign w_in_hunt   = (r_state == ST_HUNT);
    assign w_tmo_clear = bus.rx_valid | w_in_hunt;
    assign w_chk_ok    = (bus.rx_data == frame_sum(HEADER, r_cmd, r_data));
    assign w_cmd_ok    = (r_cmd[7:2] == CMD_PREFIX);

    protocol_in_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .clk_in   (clk_in),
        .reset    (reset),
        .i_clear  (w_tmo_clear),
        .i_enable (~w_in_hunt),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_cmd   = 1'b0;
        w_lat_data  = 1'b0;
        w_write     = 1'b0;
        w_err       = 1'b0;
        w_err_val   = ERR_NONE;
        case (r_state)
            ST_HUNT: begin
                if (bus.rx_valid && (bus.rx_data == HEADER)) begin
                    w_state_nxt = ST_GOT_HDR;
                end
            end
            ST_GOT_HDR: begin
                if (bus.rx_valid) begin
                    w_lat_cmd   = 1'b1;
                    w_state_nxt = ST_GOT_CMD;
                end else if (w_expire) begin
                    w_err       = 1'b1;
                    w_err_val   = ERR_TMO;
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_GOT_CMD: begin
                if (bus.rx_valid) begin
                    w_lat_data  = 1'b1;
                    w_state_nxt = ST_GOT_DATA;
                end else if (w_expire) begin
                    w_err       = 1'b1;
                    w_err_val   = ERR_TMO;
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_GOT_DATA: begin
                // Checksum failure outranks a bad command code
                if (bus.rx_valid) begin
                    w_state_nxt = ST_HUNT;
                    if (!w_chk_ok) begin
                        w_err     = 1'b1;
                        w_err_val = ERR_CHK;
                    end else if (!w_cmd_ok) begin
                        w_err     = 1'b1;
                        w_err_val = ERR_CMD;
                    end else begin
                        w_write   = 1'b1;
                    end
                end else if (w_expire) begin
                    w_err       = 1'b1;
                    w_err_val   = ERR_TMO;
                    w_state_nxt = ST_HUNT;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_cmd             <= '0;
            r_data            <= '0;
            r_regs[ADDR_SW]   <= SW_RESET_VAL;
            r_regs[ADDR_CHAN] <= 8'hFF;
            r_regs[ADDR_GATE] <= 8'h00;
            r_regs[ADDR_RSVD] <= 8'h00;
            r_cmd_valid       <= 1'b0;
            r_frame_err       <= 1'b0;
            r_cmd_addr        <= ADDR_SW;
            r_err_code        <= ERR_NONE;
        end else begin
            r_cmd_valid <= w_write;
            r_frame_err <= w_err;
            if (w_lat_cmd) begin
                r_cmd <= bus.rx_data;
            end
            if (w_lat_data) begin
                r_data <= bus.rx_data;
            end
            if (w_write) begin
                r_regs[r_cmd[1:0]] <= r_data;
                r_cmd_addr         <= r_cmd[1:0];
            end
            // Sticky: a good frame leaves the last cause in place
            if (w_err) begin
                r_err_code <= w_err_val;
            end
        end
    end

    assign bus.sw_out    = r_regs[ADDR_SW];
    assign bus.chan_mask = r_regs[ADDR_CHAN];
    assign bus.gate_div  = r_regs[ADDR_GATE];
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_addr  = r_cmd_addr;
    assign bus.frame_err = r_frame_err;
    assign bus.err_code  = r_err_code;
    assign bus.busy      = ~w_in_hunt;

endmodule
`default_nettype wire

// File: doc/protocol_in.md
Name: protocol_in

Overview:
- Receive-side frame decoder, the inverse of the protocol encoder on the transmit path.
- Consumes byte strobes from a UART byte receiver, hunts for a header, and assembles 4-byte command frames: HEADER, CMD, DATA, CHK.
- Validates each frame and writes a small configuration register file.
- Drives sw_out and channel configuration to the rest of the design, and reports framing errors.

Parameters:
- HEADER, 8'hAA, frame start byte.
- TIMEOUT_CYCLES, 2400, max clk_in cycles between bytes inside a frame (0.25 s at 9600 Hz).
- SW_RESET_VAL, 8'h00, reset value of register 0 (sw_out).

Ports:
- clk_in  input  1  system clock (9600 Hz bit clock domain)
- reset  input  1  asynchronous active-low reset
- rx_data  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- sw_out  output  8  register 0
- chan_mask  output  8  register 1
- gate_div  output  8  register 2
- cmd_valid  output  1  one-cycle pulse: a good frame was applied
- cmd_addr  output  2  address of the last good frame
- frame_err  output  1  one-cycle pulse on any rejected frame
- err_code  output  2  sticky cause of the last error: 0 none, 1 checksum, 2 bad cmd, 3 timeout
- busy  output  1  high whenever the FSM is not in HUNT

Behaviour:
- Reset (reset=0, async):
  - FSM=HUNT; sw_out=SW_RESET_VAL; chan_mask=8'hFF; gate_div=8'h00; register 3 = 0.
  - cmd_valid=0, frame_err=0, err_code=0, cmd_addr=0, busy=0, timeout counter=0.
- FSM states: HUNT, GOT_HDR, GOT_CMD, GOT_DATA.
  - HUNT: on rx_valid with rx_data==HEADER, go to GOT_HDR. Other bytes are discarded silently, with no error.
  - GOT_HDR: on rx_valid, latch CMD and go to GOT_CMD.
  - GOT_CMD: on rx_valid, latch DATA and go to GOT_DATA.
  - GOT_DATA: on rx_valid, treat the byte as CHK, evaluate the frame and return to HUNT in the same edge.
- Header bytes inside a frame are ordinary payload. There is no mid-frame resync; recovery from a lost byte is by timeout only.
- Checksum: CHK must equal (HEADER + CMD + DATA) mod 256, computed as an 8-bit wrapping sum.
- Command decode: CMD[7:2] must be 6'b000001. CMD[1:0] selects register 0..3; register 3 is writable but not exported.
- Frame evaluation, in priority order:
  - Checksum mismatch: frame_err pulse, err_code=1, no write.
  - Bad CMD: frame_err pulse, err_code=2, no write.
  - Otherwise:
    - reg[CMD[1:0]] <= DATA.
    - cmd_addr <= CMD[1:0].
    - cmd_valid pulse.
    - err_code is unchanged.
- Latency: the register, cmd_valid, frame_err and err_code update on the clk_in edge that samples the CHK strobe. The new value is visible the following cycle.
- Timeout:
  - The counter clears on every accepted rx_valid and in HUNT; it increments each cycle in the other states.
  - When the count reaches TIMEOUT_CYCLES-1 with no rx_valid: go to HUNT, frame_err pulse, err_code=3.
  - If rx_valid arrives on that same cycle, the byte wins and there is no timeout.
  - The counter saturates and never wraps.
- Pulse outputs never stay high for two consecutive cycles. Back-to-back frames may produce cmd_valid pulses as close as 4 cycles apart.
- rx_valid held high for several cycles counts as one byte per cycle. Upstream guarantees single-cycle strobes.
- Reset mid-frame: partial CMD/DATA are discarded and all registers return to their reset values.
- err_code is cleared only by reset.

Decomposition:
- Shared package:
  - HEADER default.
  - FSM state encoding (2-bit localparams).
  - err_code values (ERR_NONE, ERR_CHK, ERR_CMD, ERR_TMO).
  - Register address constants (ADDR_SW=0, ADDR_CHAN=1, ADDR_GATE=2, ADDR_RSVD=3).
  - Valid CMD prefix 6'b000001.
- One sub-module: frame_timeout, a saturating inter-byte counter. Inputs: clear, enable. Output: expire pulse. Parameter: TIMEOUT_CYCLES.
- The register file and checksum stay inline.

Test Plan:
- Good write: bytes AA,04,5A,(AA+04+5A)=08 -> sw_out=8'h5A one cycle after the CHK strobe; cmd_valid=1 for 1 cycle; cmd_addr=0; err_code=0.
- Bad checksum: AA,05,33,00 -> chan_mask stays 8'hFF; frame_err pulse; err_code=1; FSM back in HUNT (busy=0).
- Bad command: AA,10,77,(AA+10+77)=31 -> no register change; frame_err pulse; err_code=2. A subsequent good frame AA,06,03,B3 -> gate_div=8'h03 and err_code stays 2.
- Garbage then frame: 00,FF,AA,04,11,BF -> only one cmd_valid, sw_out=8'h11, no frame_err for the leading bytes.
- Timeout: AA,04, then silence for TIMEOUT_CYCLES cycles -> frame_err and err_code=3 exactly at expiry; busy falls. A byte arriving on the expiry cycle instead suppresses the timeout.
- Async reset mid-frame: AA,05,then reset low for 1 cycle -> all outputs at reset values immediately. A following good frame AA,05,C0,6F -> chan_mask=8'hC0.
